frame_builder: RTL and testbench

Transmit-side framer for the 16-bit serial link. It pops one 140-bit entry (payload, channel, word count) from the outbound FIFO and serialises it as a frame:
- two header words E0E0h;
- a channel word;
- 1–8 payload words;
- a CRC word;
- two tail words 0E0Eh.

CRC-16 arithmetic is delegated to the shared combinational CRC block through the same three-signal interface the receive side uses. The block sits between the TX FIFO and the link serialiser, and is the counterpart of the frame parser on the far end.

---
 rtl/frame_builder.sv | 171 +++++++++++++++++
 tb/tb_frame_builder.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_builder.sv
// Transmit framer: pops one FIFO entry and serialises it as
// header, channel, payload, CRC and tail words on the 16-bit link.
//
// state | meaning
// IDLE  | link quiet; issues the one-cycle FIFO pop, then moves to LOAD
// LOAD  | entry read data valid; latched and length-checked
// HDR0  | first E0E0h header word on the link
// HDR1  | second E0E0h header word on the link
// CHAN  | channel word on the link
// DATA  | payload word on the link, CRC running
// CRCW  | final CRC word on the link
// TAIL0 | first 0E0Eh tail word on the link
// TAIL1 | second 0E0Eh tail word on the link
// GAP   | zero words enforcing the inter-frame gap
module frame_builder #(
   parameter int IDLE_GAP = 2
) (
   input  logic         clk_in,
   input  logic         rst,
   input  logic         tx_en,
   input  logic         fifo_empty,
   output logic         fifo_r_enable,
   input  logic [139:0] data_from_fifo,
   output logic [15:0]  data_out,
   output logic         frame_valid,
   output logic         len_err,
   output logic [15:0]  data_to_crc,
   output logic [15:0]  crc,
   input  logic [15:0]  data_from_crc
);

   localparam logic [15:0] HDR_WORD   = 16'hE0E0;
   localparam logic [15:0] TAIL_WORD  = 16'h0E0E;
   // A fetch decided in TAIL1 already yields two zero words (pop + LOAD),
   // so only the remainder beyond two has to be counted down.
   localparam logic [7:0]  GAP_RELOAD = 8'(IDLE_GAP - 2);

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_HDR0, S_HDR1, S_CHAN,
      S_DATA, S_CRCW, S_TAIL0, S_TAIL1, S_GAP
   } state_t;

   state_t        state;
   logic [127:0]  payload_q;
   logic [7:0]    chan_q;
   logic [3:0]    len_q;
   logic [2:0]    word_idx;
   logic [7:0]    gap_cnt;

   logic          can_fetch;
   logic          len_ok;
   logic          last_word;
   logic [2:0]    idx_next;
   logic [15:0]   next_word;

   assign can_fetch = tx_en && !fifo_empty && (gap_cnt == 8'd0);
   assign len_ok    = (data_from_fifo[3:0] != 4'd0) && (data_from_fifo[3:0] <= 4'd8);
   assign last_word = ({1'b0, word_idx} == (len_q - 4'd1));
   assign idx_next  = word_idx + 3'd1;

   always_comb begin
      next_word = payload_q[127:112];
      case (idx_next)
         3'd0: next_word = payload_q[127:112];
         3'd1: next_word = payload_q[111:96];
         3'd2: next_word = payload_q[95:80];
         3'd3: next_word = payload_q[79:64];
         3'd4: next_word = payload_q[63:48];
         3'd5: next_word = payload_q[47:32];
         3'd6: next_word = payload_q[31:16];
         3'd7: next_word = payload_q[15:0];
         default: next_word = payload_q[127:112];
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state         <= S_IDLE;
         fifo_r_enable <= 1'b0;
         data_out      <= 16'h0000;
         frame_valid   <= 1'b0;
         len_err       <= 1'b0;
         data_to_crc   <= 16'h0000;
         crc           <= 16'h0000;
         payload_q     <= '0;
         chan_q        <= 8'h00;
         len_q         <= 4'd0;
         word_idx      <= 3'd0;
         gap_cnt       <= 8'd0;
      end else begin
         len_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (fifo_r_enable) begin
                  fifo_r_enable <= 1'b0;
                  state         <= S_LOAD;
               end else if (can_fetch) begin
                  fifo_r_enable <= 1'b1;
               end
            end
            S_LOAD: begin
               payload_q <= data_from_fifo[139:12];
               chan_q    <= data_from_fifo[11:4];
               len_q     <= data_from_fifo[3:0];
               if (len_ok) begin
                  data_out    <= HDR_WORD;
                  frame_valid <= 1'b1;
                  state       <= S_HDR0;
               end else begin
                  // discarded entry: the next pop may go out immediately
                  len_err <= 1'b1;
                  state   <= S_IDLE;
                  if (can_fetch) fifo_r_enable <= 1'b1;
               end
            end
            S_HDR0: begin
               data_out <= HDR_WORD;
               state    <= S_HDR1;
            end
            S_HDR1: begin
               data_out <= {8'h00, chan_q};
               state    <= S_CHAN;
            end
            S_CHAN: begin
               data_out    <= payload_q[127:112];
               data_to_crc <= payload_q[127:112];
               crc         <= 16'h0000;
               word_idx    <= 3'd0;
               state       <= S_DATA;
            end
            S_DATA: begin
               if (last_word) begin
                  data_out    <= data_from_crc;
                  data_to_crc <= 16'h0000;
                  crc         <= 16'h0000;
                  state       <= S_CRCW;
               end else begin
                  word_idx    <= idx_next;
                  data_out    <= next_word;
                  data_to_crc <= next_word;
                  crc         <= data_from_crc;
               end
            end
            S_CRCW: begin
               data_out <= TAIL_WORD;
               state    <= S_TAIL0;
            end
            S_TAIL0: begin
               data_out <= TAIL_WORD;
               gap_cnt  <= GAP_RELOAD;
               state    <= S_TAIL1;
            end
            S_TAIL1, S_GAP: begin
               data_out    <= 16'h0000;
               frame_valid <= 1'b0;
               if (can_fetch) begin
                  fifo_r_enable <= 1'b1;
                  state         <= S_IDLE;
               end else if (gap_cnt != 8'd0) begin
                  gap_cnt <= gap_cnt - 8'd1;
                  state   <= S_GAP;
               end else begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_builder.sv
// Self-checking bench for frame_builder: a FIFO model feeds random entries and
// a frame-level reference model predicts every word, gap and pulse position.
module tb_frame_builder;

   localparam int IDLE_GAP = 2;

   logic          clk_in = 1'b0;
   logic          rst;
   logic          tx_en;
   logic          fifo_empty = 1'b1;
   logic          fifo_r_enable;
   logic [139:0]  data_from_fifo = '0;
   logic [15:0]   data_out;
   logic          frame_valid;
   logic          len_err;
   logic [15:0]   data_to_crc;
   logic [15:0]   crc;
   logic [15:0]   data_from_crc;

   typedef struct packed {
      int              len;
      int              start;
      logic [15:0][15:0] w;
      logic [15:0][15:0] dc;
      logic [15:0][15:0] cc;
   } frame_t;

   frame_t        frames[$];
   frame_t        cur = '0;
   int            pops[$];
   int            lerrs[$];
   logic [139:0]  fifo_q[$];
   int            cyc = 0;
   int            underflow_cnt = 0;
   int            idle_bad = 0;
   int            tests_run = 0;
   int            fail_cnt = 0;
   bit            force_crc = 1'b0;

   frame_builder #(.IDLE_GAP(IDLE_GAP)) dut (
      .clk_in        (clk_in),
      .rst           (rst),
      .tx_en         (tx_en),
      .fifo_empty    (fifo_empty),
      .fifo_r_enable (fifo_r_enable),
      .data_from_fifo(data_from_fifo),
      .data_out      (data_out),
      .frame_valid   (frame_valid),
      .len_err       (len_err),
      .data_to_crc   (data_to_crc),
      .crc           (crc),
      .data_from_crc (data_from_crc)
   );

   always #5 clk_in = ~clk_in;

   // CRC-16/CCITT polynomial, one 16-bit word per step, MSB first
   function automatic logic [15:0] crc16(input logic [15:0] c, input logic [15:0] d);
      logic [15:0] r;
      logic        fb;
      r = c;
      for (int i = 15; i >= 0; i--) begin
         fb = r[15] ^ d[i];
         r  = {r[14:0], 1'b0};
         if (fb) r = r ^ 16'h1021;
      end
      return r;
   endfunction

   assign data_from_crc = force_crc ? 16'hABCD : crc16(crc, data_to_crc);

   function automatic logic [139:0] rand_entry(input int n, input logic [7:0] ch);
      logic [127:0] p;
      p = {$urandom, $urandom, $urandom, $urandom};
      return {p, ch, 4'(n)};
   endfunction

   function automatic frame_t model_frame(input logic [139:0] e, input bit forced);
      frame_t        f;
      int            n;
      logic [15:0]   c;
      logic [139:0]  sh;
      f = '0;
      n = int'(e[3:0]);
      f.w[0] = 16'hE0E0;
      f.w[1] = 16'hE0E0;
      f.w[2] = {8'h00, e[11:4]};
      c = 16'h0000;
      for (int i = 0; i < n; i++) begin
         sh = e << (16 * i);
         f.w[3 + i] = sh[139:124];
         c = crc16(c, sh[139:124]);
      end
      f.w[3 + n] = forced ? 16'hABCD : c;
      f.w[4 + n] = 16'h0E0E;
      f.w[5 + n] = 16'h0E0E;
      f.len = n + 6;
      return f;
   endfunction

   // index of first differing word, 99 on length mismatch, -1 when identical
   function automatic int frame_diff(input frame_t a, input frame_t b);
      if (a.len != b.len || a.len > 16) return 99;
      for (int i = 0; i < a.len; i++)
         if (a.w[i] !== b.w[i]) return i;
      return -1;
   endfunction

   function automatic logic [139:0] parse_entry(input frame_t f);
      logic [127:0] p;
      int           n;
      p = '0;
      n = f.len - 6;
      for (int i = 0; i < n && i < 8; i++) p[127 - 16 * i -: 16] = f.w[3 + i];
      return {p, f.w[2][7:0], 4'(n)};
   endfunction

   // FIFO model and link monitor, both observed mid-cycle
   always @(negedge clk_in) begin
      cyc = cyc + 1;
      if (fifo_r_enable) begin
         pops.push_back(cyc);
         if (fifo_q.size() == 0) underflow_cnt = underflow_cnt + 1;
         else data_from_fifo = fifo_q.pop_front();
      end
      fifo_empty = (fifo_q.size() == 0);
      if (len_err) lerrs.push_back(cyc);
      if (frame_valid) begin
         if (cur.len == 0) cur.start = cyc;
         if (cur.len < 16) begin
            cur.w[cur.len]  = data_out;
            cur.dc[cur.len] = data_to_crc;
            cur.cc[cur.len] = crc;
         end
         cur.len = cur.len + 1;
      end else begin
         if (data_out != 16'h0000 || data_to_crc != 16'h0000 || crc != 16'h0000)
            idle_bad = idle_bad + 1;
         if (cur.len != 0) begin
            frames.push_back(cur);
            cur = '0;
         end
      end
   end

   task automatic wait_frames(input int n, input int budget, output bit ok);
      int k;
      k = 0;
      while (frames.size() < n && k < budget) begin
         @(negedge clk_in);
         k++;
      end
      ok = (frames.size() >= n);
   endtask

   task automatic wait_chan(input logic [7:0] ch, input int budget, output bit ok);
      int k;
      k = 0;
      ok = 1'b0;
      while (!ok && k < budget) begin
         @(posedge clk_in);
         #1;
         ok = frame_valid && (data_out == {8'h00, ch});
         k++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tx_en = 1'b0;
      repeat (3) @(posedge clk_in);
      #1;
      tests_run++; if (data_out !== 16'h0000) begin fail_cnt++; $display("FAIL reset_data_out: got %h expected 0000", data_out); end
      tests_run++; if (frame_valid !== 1'b0) begin fail_cnt++; $display("FAIL reset_frame_valid: got %b expected 0", frame_valid); end
      tests_run++; if (fifo_r_enable !== 1'b0) begin fail_cnt++; $display("FAIL reset_fifo_r_enable: got %b expected 0", fifo_r_enable); end
      tests_run++; if (len_err !== 1'b0) begin fail_cnt++; $display("FAIL reset_len_err: got %b expected 0", len_err); end
      tests_run++; if (data_to_crc !== 16'h0000) begin fail_cnt++; $display("FAIL reset_data_to_crc: got %h expected 0000", data_to_crc); end
      tests_run++; if (crc !== 16'h0000) begin fail_cnt++; $display("FAIL reset_crc: got %h expected 0000", crc); end
      @(negedge clk_in);
      rst = 1'b0;
      repeat (3) @(negedge clk_in);
   endtask

   task automatic test_single_word();
      logic [139:0] e;
      frame_t       got, exp;
      int           f0, p0, d;
      bit           ok;
      f0 = frames.size();
      p0 = pops.size();
      force_crc = 1'b1;
      e = rand_entry(1, 8'h05);
      e[139:124] = 16'h1234;
      fifo_q.push_back(e);
      tx_en = 1'b1;
      wait_frames(f0 + 1, 60, ok);
      tests_run++;
      if (!ok) begin
         fail_cnt++; $display("FAIL single_timeout: got %0d frames expected %0d", frames.size(), f0 + 1);
      end else begin
         got = frames[f0];
         exp = model_frame(e, 1'b1);
         d = frame_diff(got, exp);
         tests_run++; if (got.len != 7) begin fail_cnt++; $display("FAIL single_valid_len: got %0d expected 7", got.len); end
         tests_run++; if (d != -1) begin fail_cnt++; $display("FAIL single_words: first bad index %0d got %h expected %h", d, got.w[d & 15], exp.w[d & 15]); end
         tests_run++; if (got.dc[3] !== 16'h1234) begin fail_cnt++; $display("FAIL single_data_to_crc: got %h expected 1234", got.dc[3]); end
         tests_run++; if (got.cc[3] !== 16'h0000) begin fail_cnt++; $display("FAIL single_crc_seed: got %h expected 0000", got.cc[3]); end
         tests_run++; if (got.dc[4] !== 16'h0000) begin fail_cnt++; $display("FAIL single_crc_off_on_crcw: got %h expected 0000", got.dc[4]); end
         tests_run++;
         if (pops.size() <= p0 || got.start != pops[p0] + 2) begin
            fail_cnt++; $display("FAIL single_hdr_latency: got start %0d pops %0d expected pop+2", got.start, pops.size());
         end
      end
      repeat (4) @(negedge clk_in);
      force_crc = 1'b0;
   endtask

   task automatic test_full_frame();
      logic [139:0] e;
      logic [15:0]  c;
      frame_t       got, exp;
      int           f0, d;
      bit           ok;
      f0 = frames.size();
      e = '0;
      c = 16'h0000;
      for (int i = 0; i < 8; i++) begin
         e[139 - 16 * i -: 16] = 16'(i + 1);
         c = crc16(c, 16'(i + 1));
      end
      e[11:4] = 8'hA5;
      e[3:0]  = 4'd8;
      fifo_q.push_back(e);
      wait_frames(f0 + 1, 60, ok);
      tests_run++;
      if (!ok) begin
         fail_cnt++; $display("FAIL full_timeout: got %0d frames expected %0d", frames.size(), f0 + 1);
      end else begin
         got = frames[f0];
         exp = model_frame(e, 1'b0);
         d = frame_diff(got, exp);
         tests_run++; if (d != -1) begin fail_cnt++; $display("FAIL full_words: first bad index %0d got %h expected %h", d, got.w[d & 15], exp.w[d & 15]); end
         tests_run++; if (got.w[11] !== c) begin fail_cnt++; $display("FAIL full_crc: got %h expected %h", got.w[11], c); end
         tests_run++; if (parse_entry(got) !== e) begin fail_cnt++; $display("FAIL full_parse: got %h expected %h", parse_entry(got), e); end
      end
      repeat (4) @(negedge clk_in);
   endtask

   task automatic test_random();
      logic [139:0] ents[6];
      frame_t       exp;
      int           f0, d;
      bit           ok;
      f0 = frames.size();
      for (int i = 0; i < 6; i++) begin
         ents[i] = rand_entry($urandom_range(1, 8), 8'($urandom));
         fifo_q.push_back(ents[i]);
      end
      wait_frames(f0 + 6, 200, ok);
      tests_run++;
      if (!ok) begin
         fail_cnt++; $display("FAIL random_timeout: got %0d frames expected %0d", frames.size(), f0 + 6);
      end else begin
         for (int i = 0; i < 6; i++) begin
            exp = model_frame(ents[i], 1'b0);
            d = frame_diff(frames[f0 + i], exp);
            tests_run++;
            if (d != -1) begin
               fail_cnt++; $display("FAIL random_frame%0d: first bad index %0d got %h expected %h", i, d, frames[f0 + i].w[d & 15], exp.w[d & 15]);
            end
         end
      end
      repeat (4) @(negedge clk_in);
   endtask

   task automatic test_back_to_back();
      logic [139:0] ents[3];
      int           f0, p0, gap, lat;
      bit           ok;
      f0 = frames.size();
      p0 = pops.size();
      for (int i = 0; i < 3; i++) begin
         ents[i] = rand_entry(3, 8'(8'h10 + i));
         fifo_q.push_back(ents[i]);
      end
      wait_frames(f0 + 3, 100, ok);
      tests_run++;
      if (!ok || pops.size() < p0 + 3) begin
         fail_cnt++; $display("FAIL b2b_timeout: got %0d frames expected %0d", frames.size(), f0 + 3);
      end else begin
         for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (frame_diff(frames[f0 + k], model_frame(ents[k], 1'b0)) != -1) begin
               fail_cnt++; $display("FAIL b2b_frame%0d: got start word %h len %0d expected len 9", k, frames[f0 + k].w[0], frames[f0 + k].len);
            end
         end
         for (int k = 0; k < 2; k++) begin
            gap = frames[f0 + k + 1].start - (frames[f0 + k].start + frames[f0 + k].len);
            lat = pops[p0 + k + 1] - (frames[f0 + k].start + frames[f0 + k].len);
            tests_run++; if (gap != IDLE_GAP) begin fail_cnt++; $display("FAIL b2b_gap%0d: got %0d expected %0d", k, gap, IDLE_GAP); end
            tests_run++; if (lat != 0) begin fail_cnt++; $display("FAIL b2b_pop%0d: got %0d cycles after tail expected 1", k, lat + 1); end
         end
      end
      repeat (4) @(negedge clk_in);
   endtask

   task automatic test_bad_length();
      logic [139:0] e0, e9, e2;
      int           f0, p0, l0;
      bit           ok;
      f0 = frames.size();
      p0 = pops.size();
      l0 = lerrs.size();
      e0 = rand_entry(0, 8'h21);
      e9 = rand_entry(9, 8'h22);
      e2 = rand_entry(2, 8'h23);
      fifo_q.push_back(e0);
      fifo_q.push_back(e9);
      fifo_q.push_back(e2);
      wait_frames(f0 + 1, 60, ok);
      repeat (20) @(negedge clk_in);
      tests_run++;
      if (!ok || pops.size() < p0 + 3) begin
         fail_cnt++; $display("FAIL badlen_timeout: got %0d frames %0d pops expected %0d frames", frames.size(), pops.size() - p0, f0 + 1);
      end else begin
         tests_run++; if (lerrs.size() - l0 != 2) begin fail_cnt++; $display("FAIL badlen_pulses: got %0d expected 2", lerrs.size() - l0); end
         tests_run++; if (frames.size() != f0 + 1) begin fail_cnt++; $display("FAIL badlen_frames: got %0d expected %0d", frames.size() - f0, 1); end
         tests_run++; if (pops[p0 + 1] - pops[p0] != 2) begin fail_cnt++; $display("FAIL badlen_refetch: got %0d expected 2", pops[p0 + 1] - pops[p0]); end
         tests_run++; if (frames[f0].start - pops[p0 + 2] != 2) begin fail_cnt++; $display("FAIL badlen_hdr_latency: got %0d expected 2", frames[f0].start - pops[p0 + 2]); end
         tests_run++; if (frame_diff(frames[f0], model_frame(e2, 1'b0)) != -1) begin fail_cnt++; $display("FAIL badlen_good_frame: got len %0d expected 8", frames[f0].len); end
         if (lerrs.size() - l0 == 2) begin
            tests_run++; if (lerrs[l0] - pops[p0] != 2) begin fail_cnt++; $display("FAIL badlen_pulse_time: got %0d expected 2", lerrs[l0] - pops[p0]); end
         end
      end
   endtask

   task automatic test_flow_control();
      logic [139:0] ea, eb;
      int           f0, p0, u0;
      bit           ok;
      f0 = frames.size();
      p0 = pops.size();
      u0 = underflow_cnt;
      ea = rand_entry(4, 8'h4A);
      eb = rand_entry(2, 8'h4B);
      fifo_q.push_back(ea);
      fifo_q.push_back(eb);
      wait_chan(8'h4A, 60, ok);
      @(posedge clk_in);
      #1;
      tx_en = 1'b0;
      wait_frames(f0 + 1, 60, ok);
      repeat (30) @(negedge clk_in);
      tests_run++; if (!ok || frame_diff(frames[f0], model_frame(ea, 1'b0)) != -1) begin fail_cnt++; $display("FAIL flow_frame_completes: got %0d frames expected %0d", frames.size(), f0 + 1); end
      tests_run++; if (pops.size() - p0 != 1) begin fail_cnt++; $display("FAIL flow_no_fetch: got %0d pops expected 1", pops.size() - p0); end
      tx_en = 1'b1;
      wait_frames(f0 + 2, 60, ok);
      tests_run++; if (!ok || frame_diff(frames[f0 + 1], model_frame(eb, 1'b0)) != -1) begin fail_cnt++; $display("FAIL flow_resume: got %0d frames expected %0d", frames.size(), f0 + 2); end
      repeat (60) @(negedge clk_in);
      tests_run++; if (pops.size() - p0 != 2) begin fail_cnt++; $display("FAIL flow_empty_pops: got %0d expected 2", pops.size() - p0); end
      tests_run++; if (underflow_cnt != u0) begin fail_cnt++; $display("FAIL flow_underflow: got %0d expected %0d", underflow_cnt, u0); end
   endtask

   task automatic test_reset_mid_frame();
      logic [139:0] ea, eb;
      int           f0, p0;
      bit           ok;
      f0 = frames.size();
      p0 = pops.size();
      ea = rand_entry(3, 8'h3C);
      eb = rand_entry(5, 8'hC3);
      fifo_q.push_back(ea);
      fifo_q.push_back(eb);
      wait_chan(8'h3C, 60, ok);
      tests_run++;
      if (!ok) begin
         fail_cnt++; $display("FAIL rstmid_no_chan: got %0d frames expected a frame with channel 3c", frames.size() - f0);
      end else begin
         rst = 1'b1;
         @(posedge clk_in);
         #1;
         tests_run++; if (data_out !== 16'h0000) begin fail_cnt++; $display("FAIL rstmid_data_out: got %h expected 0000", data_out); end
         tests_run++; if (frame_valid !== 1'b0) begin fail_cnt++; $display("FAIL rstmid_frame_valid: got %b expected 0", frame_valid); end
         rst = 1'b0;
         wait_frames(f0 + 2, 60, ok);
         repeat (10) @(negedge clk_in);
         tests_run++; if (!ok || frames[f0].len != 3) begin fail_cnt++; $display("FAIL rstmid_truncated: got %0d frames expected truncated len 3", frames.size() - f0); end
         tests_run++; if (!ok || frame_diff(frames[f0 + 1], model_frame(eb, 1'b0)) != -1) begin fail_cnt++; $display("FAIL rstmid_next_frame: got %0d frames expected entry B framed", frames.size() - f0); end
         tests_run++; if (pops.size() - p0 != 2) begin fail_cnt++; $display("FAIL rstmid_no_repop: got %0d pops expected 2", pops.size() - p0); end
      end
   endtask

   initial begin
      rst = 1'b1;
      tx_en = 1'b0;
      test_reset();
      test_single_word();
      test_full_frame();
      test_random();
      test_back_to_back();
      test_bad_length();
      test_flow_control();
      test_reset_mid_frame();
      tests_run++; if (idle_bad != 0) begin fail_cnt++; $display("FAIL idle_words_zero: got %0d nonzero idle cycles expected 0", idle_bad); end
      tests_run++; if (underflow_cnt != 0) begin fail_cnt++; $display("FAIL pop_while_empty: got %0d expected 0", underflow_cnt); end
      $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish within 50000 cycles");
      $fatal(1, "watchdog expired");
   end

endmodule
